// File: rtl/layer_link_ctrl.sv
// Sequencer between one layer's output stream and the next fc layer's input buffer / CIM handshake.
// Optional bubble counter (o_stall_cycles) is built when LAYER_LINK_STALL_CNT_EN is defined.
module layer_link_ctrl #(
    parameter int input_size    = 720,
    parameter int datatype_size = 2,
    parameter int cim_latency   = 8,
    localparam int addr_w       = (input_size > 1) ? $clog2(input_size) : 1,
    localparam int cim_w        = $clog2(cim_latency + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_up_valid,
    input  logic [datatype_size-1:0] i_up_data,
    output logic                     o_up_ready,
    output logic                     o_ibuf_we,
    output logic [datatype_size-1:0] o_ibuf_wr_data,
    output logic [addr_w-1:0]        o_ibuf_addr,
    output logic                     o_start,
    input  logic                     i_busy,
    output logic                     o_cim_busy,
    input  logic                     i_next_busy,
    output logic                     o_func_start,
    output logic [15:0]              o_frames
`ifdef LAYER_LINK_STALL_CNT_EN
    ,
    output logic [31:0]              o_stall_cycles
`endif
);

    typedef enum logic [2:0] {FILL, START, CIM, FUNC, DRAIN} state_t;

    localparam logic [addr_w-1:0] last_addr = addr_w'(input_size - 1);

    state_t                     state_q, state_d;
    logic [addr_w-1:0]          count_q, count_d;
    logic [cim_w-1:0]           cim_q, cim_d;
    logic                       ready_d, we_d, start_d, cim_busy_d, func_start_d;
    logic [datatype_size-1:0]   wr_data_d;
    logic [addr_w-1:0]          addr_d;
    logic [15:0]                frames_d;
    logic                       hs;

    assign hs = i_up_valid && o_up_ready;

    // Every output is produced here as a next value and then registered below.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        count_d      = count_q;
        cim_d        = cim_q;
        ready_d      = 1'b0;
        we_d         = 1'b0;
        wr_data_d    = o_ibuf_wr_data;
        addr_d       = o_ibuf_addr;
        start_d      = 1'b0;
        cim_busy_d   = 1'b0;
        func_start_d = 1'b0;
        frames_d     = o_frames;

        case (state_q)
            FILL: begin
                ready_d = 1'b1;
                if (hs) begin
                    we_d      = 1'b1;
                    wr_data_d = i_up_data;
                    addr_d    = count_q;
                    if (count_q == last_addr) begin
                        count_d = '0;
                        ready_d = 1'b0;
                        state_d = START;
                    end else begin
                        count_d = count_q + addr_w'(1);
                    end
                end
            end
            START: begin
                start_d    = 1'b1;
                cim_d      = cim_w'(cim_latency);
                cim_busy_d = 1'b1;
                state_d    = CIM;
            end
            CIM: begin
                // Busy is high for counter values cim_latency..1, i.e. exactly cim_latency cycles.
                if (cim_q > cim_w'(1)) begin
                    cim_d      = cim_q - cim_w'(1);
                    cim_busy_d = 1'b1;
                end else begin
                    cim_d   = '0;
                    state_d = FUNC;
                end
            end
            FUNC: begin
                if (!i_next_busy) begin
                    func_start_d = 1'b1;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (!i_busy) begin
                    frames_d = o_frames + 16'd1;
                    ready_d  = 1'b1;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q        <= FILL;
            count_q        <= '0;
            cim_q          <= '0;
            o_up_ready     <= 1'b0;
            o_ibuf_we      <= 1'b0;
            o_ibuf_wr_data <= '0;
            o_ibuf_addr    <= '0;
            o_start        <= 1'b0;
            o_cim_busy     <= 1'b0;
            o_func_start   <= 1'b0;
            o_frames       <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            cim_q          <= cim_d;
            o_up_ready     <= ready_d;
            o_ibuf_we      <= we_d;
            o_ibuf_wr_data <= wr_data_d;
            o_ibuf_addr    <= addr_d;
            o_start        <= start_d;
            o_cim_busy     <= cim_busy_d;
            o_func_start   <= func_start_d;
            o_frames       <= frames_d;
        end
    end

`ifdef LAYER_LINK_STALL_CNT_EN
    // Bubbles: downstream refusing the function start, or upstream starving an open input buffer.
    logic stall;
    assign stall = ((state_q == FUNC) && i_next_busy) ||
                   ((state_q == FILL) && o_up_ready && !i_up_valid);

    always_ff @(posedge clk) begin
        if (rst)
            o_stall_cycles <= '0;
        else if (stall && (o_stall_cycles != '1))
            o_stall_cycles <= o_stall_cycles + 32'd1;
    end
`endif

endmodule
